coreapb3_muxptob_wdog: RTL and testbench



---
 rtl/coreapb3_muxptob_wdog.sv | 141 ++++++++++++++
 tb/tb_coreapb3_muxptob_wdog.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coreapb3_muxptob_wdog.sv
// APB3 response mux with per-transfer stall watchdog and sticky status.
// Ports: PCLK/PRESETN; bridge PSEL/PENABLE in, PREADY/PSLVERR/PRDATA out;
//        per-slot PSELS/PRDATAS/PREADYS/PSLVERRS in; STAT_CLR in;
//        TO_STAT/TO_SLOT/MSEL_STAT sticky status out.
module coreapb3_muxptob_wdog #(
    parameter int NUM_SLOTS      = 17,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit DEFAULT_SLVERR = 1'b1,
    localparam int SLOTW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                            PCLK,
    input  logic                            PRESETN,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic [NUM_SLOTS-1:0]            PSELS,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATAS,
    input  logic [NUM_SLOTS-1:0]            PREADYS,
    input  logic [NUM_SLOTS-1:0]            PSLVERRS,
    output logic                            PREADY,
    output logic                            PSLVERR,
    output logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            STAT_CLR,
    output logic                            TO_STAT,
    output logic [SLOTW-1:0]                TO_SLOT,
    output logic                            MSEL_STAT
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state;
    logic [15:0]             cnt;
    logic [SLOTW-1:0]        idx;
    logic                    unm;
    logic [SLOTW-1:0]        low_idx;
    logic                    multi;
    logic                    sel_rdy;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    fire;
    logic                    eff_rdy;
    logic                    eff_err;
    logic [DATA_WIDTH-1:0]   eff_data;

    // Lowest set select wins; count selects to flag multi-hot.
    always_comb begin
        int c;
        low_idx = '0;
        c = 0;
        for (int n = NUM_SLOTS - 1; n >= 0; n--) begin
            if (PSELS[n]) low_idx = SLOTW'(n);
        end
        for (int n = 0; n < NUM_SLOTS; n++) begin
            c += int'(PSELS[n]);
        end
        multi = (c > 1);
    end

    // Response of the latched slot only; other slots never reach PRDATA.
    always_comb begin
        sel_rdy  = 1'b0;
        sel_err  = 1'b0;
        sel_data = '0;
        for (int n = 0; n < NUM_SLOTS; n++) begin
            if (idx == SLOTW'(n)) begin
                sel_rdy  = PREADYS[n];
                sel_err  = PSLVERRS[n];
                sel_data = PRDATAS[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A slave that becomes ready in the fire cycle takes precedence.
    assign fire = (TMO != 16'd0) && (cnt == TMO) && !sel_rdy && !unm;

    always_comb begin
        eff_rdy  = sel_rdy;
        eff_err  = sel_err;
        eff_data = sel_data;
        if (unm) begin
            eff_rdy  = 1'b1;
            eff_err  = DEFAULT_SLVERR;
            eff_data = '0;
        end else if (fire) begin
            eff_rdy  = 1'b1;
            eff_err  = 1'b1;
            eff_data = '0;
        end
    end

    assign PREADY  = (state == ACCESS) ? eff_rdy : 1'b1;
    assign PSLVERR = (state == ACCESS) ? eff_err : 1'b0;
    assign PRDATA  = (state == ACCESS) ? eff_data : '0;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            unm       <= 1'b0;
            TO_STAT   <= 1'b0;
            TO_SLOT   <= '0;
            MSEL_STAT <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below overrides it.
            if (STAT_CLR) begin
                TO_STAT   <= 1'b0;
                TO_SLOT   <= '0;
                MSEL_STAT <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        idx   <= low_idx;
                        unm   <= ~|PSELS;
                        cnt   <= '0;
                        state <= ACCESS;
                        if (multi) MSEL_STAT <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!PSEL || !PENABLE) begin
                        state <= IDLE;
                    end else if (eff_rdy) begin
                        state <= IDLE;
                        if (fire) begin
                            TO_STAT <= 1'b1;
                            TO_SLOT <= idx;
                        end
                    end else if (cnt < TMO) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coreapb3_muxptob_wdog.sv
// Randomized bench for coreapb3_muxptob_wdog against a transfer-level model.
// Ports: drives every DUT input, checks all outputs with immediate asserts.
module tb_coreapb3_muxptob_wdog;

    localparam int NS = 17;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam bit DS = 1'b1;
    localparam int SW = 5;

    logic               clk;
    logic               rst_n;
    logic               psel;
    logic               penable;
    logic [NS-1:0]      psels;
    logic [NS*DW-1:0]   rdatas;
    logic [NS-1:0]      preadys;
    logic [NS-1:0]      pslverrs;
    logic               pready;
    logic               pslverr;
    logic [DW-1:0]      prdata;
    logic               stat_clr;
    logic               to_stat;
    logic [SW-1:0]      to_slot;
    logic               msel;

    int  n_chk;
    int  n_fail;
    bit  m_to;
    bit  m_ms;
    int  m_slot;
    bit  fix;
    logic [DW-1:0] fixd;

    coreapb3_muxptob_wdog #(
        .NUM_SLOTS(NS),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO),
        .DEFAULT_SLVERR(DS)
    ) dut (
        .PCLK(clk),
        .PRESETN(rst_n),
        .PSEL(psel),
        .PENABLE(penable),
        .PSELS(psels),
        .PRDATAS(rdatas),
        .PREADYS(preadys),
        .PSLVERRS(pslverrs),
        .PREADY(pready),
        .PSLVERR(pslverr),
        .PRDATA(prdata),
        .STAT_CLR(stat_clr),
        .TO_STAT(to_stat),
        .TO_SLOT(to_slot),
        .MSEL_STAT(msel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_slots();
        for (int i = 0; i < NS; i++) rdatas[i*DW +: DW] = $urandom;
        preadys  = NS'($urandom);
        pslverrs = NS'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"}, 32'(pready), 32'd1);
        chk({tag, "_err"}, 32'(pslverr), 32'd0);
        chk({tag, "_data"}, prdata, 32'd0);
        chk({tag, "_to"}, 32'(to_stat), 32'(m_to));
        chk({tag, "_ms"}, 32'(msel), 32'(m_ms));
        if (m_to) chk({tag, "_slot"}, 32'(to_slot), 32'(m_slot));
    endtask

    // One transfer: stall = access cycles the slave holds PREADY low.
    task automatic xfer(input logic [NS-1:0] sels, input int stall,
                        input bit serr, input bit clr);
        int  s;
        int  last;
        bit  unm;
        bit  tmo;
        logic [DW-1:0] d;
        @(negedge clk);
        psel = 1'b1;
        penable = 1'b0;
        psels = sels;
        stat_clr = clr;
        rnd_slots();
        unm = (sels == '0);
        s = 0;
        for (int i = NS - 1; i >= 0; i--) if (sels[i]) s = i;
        if (clr) m_to = 1'b0;
        m_ms = ($countones(sels) > 1) || (m_ms && !clr);
        tmo = !unm && (TO != 0) && (stall > TO);
        last = unm ? 1 : (tmo ? TO + 1 : stall + 1);
        @(negedge clk);
        penable = 1'b1;
        stat_clr = 1'b0;
        for (int k = 1; k <= last; k++) begin
            rnd_slots();
            psels = NS'($urandom);
            if (!unm) begin
                preadys[s]  = (k > stall);
                pslverrs[s] = serr;
                if (fix) rdatas[s*DW +: DW] = fixd;
            end
            d = rdatas[s*DW +: DW];
            #1;
            if (k < last) begin
                chk("wait_rdy", 32'(pready), 32'd0);
                chk("wait_err", 32'(pslverr), 32'(serr));
                chk("wait_data", prdata, d);
                @(negedge clk);
            end else if (unm) begin
                chk("unm_rdy", 32'(pready), 32'd1);
                chk("unm_err", 32'(pslverr), 32'(DS));
                chk("unm_data", prdata, 32'd0);
            end else if (tmo) begin
                chk("tmo_rdy", 32'(pready), 32'd1);
                chk("tmo_err", 32'(pslverr), 32'd1);
                chk("tmo_data", prdata, 32'd0);
            end else begin
                chk("done_rdy", 32'(pready), 32'd1);
                chk("done_err", 32'(pslverr), 32'(serr));
                chk("done_data", prdata, d);
            end
        end
        @(negedge clk);
        psel = 1'b0;
        penable = 1'b0;
        if (tmo) begin
            m_to = 1'b1;
            m_slot = s;
        end
        #1;
        chk_idle("post");
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        m_to = 1'b0;
        m_ms = 1'b0;
        #1;
        chk("clr_to", 32'(to_stat), 32'd0);
        chk("clr_ms", 32'(msel), 32'd0);
    endtask

    initial begin
        logic [NS-1:0] sv;
        n_chk = 0;
        n_fail = 0;
        m_to = 1'b0;
        m_ms = 1'b0;
        m_slot = 0;
        fix = 1'b0;
        fixd = '0;
        rst_n = 1'b0;
        psel = 1'b0;
        penable = 1'b0;
        psels = '0;
        stat_clr = 1'b0;
        rnd_slots();
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fix = 1'b1;
        fixd = 32'hA5A5_1234;
        sv = '0; sv[5] = 1'b1;
        xfer(sv, 0, 1'b0, 1'b0);
        fix = 1'b0;

        sv = '0; sv[16] = 1'b1;
        xfer(sv, 3, 1'b0, 1'b0);

        sv = '0; sv[2] = 1'b1;
        xfer(sv, 1000, 1'b0, 1'b0);
        clr_pulse();

        xfer('0, 0, 1'b0, 1'b0);

        sv = NS'(32'h0000C);
        xfer(sv, 1, 1'b0, 1'b0);
        xfer(sv, 0, 1'b1, 1'b1);

        sv = '0; sv[4] = 1'b1;
        xfer(sv, TO, 1'b1, 1'b0);

        sv = '0; sv[7] = 1'b1;
        xfer(sv, TO + 1, 1'b0, 1'b0);

        // Reset on the second stalled access cycle.
        @(negedge clk);
        psel = 1'b1;
        penable = 1'b0;
        psels = '0;
        psels[3] = 1'b1;
        @(negedge clk);
        penable = 1'b1;
        preadys = '0;
        #1;
        chk("rst_stall", 32'(pready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        m_to = 1'b0;
        m_ms = 1'b0;
        #1;
        chk_idle("midrst");
        psel = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sv = '0; sv[0] = 1'b1;
        xfer(sv, 0, 1'b0, 1'b0);
        sv = '0; sv[1] = 1'b1;
        xfer(sv, TO, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) sv = '0;
            else if (r == 1) sv = NS'($urandom);
            else begin
                sv = '0;
                sv[$urandom_range(0, NS - 1)] = 1'b1;
            end
            xfer(sv, $urandom_range(0, 6), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
